// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback. It drives every datapath enable and mux select, and supplies
// ALUOp to alu_control. It also counts retired instructions and traps
// illegal opcodes in a state that only reset can leave.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_we,
  output logic                   ir_we,
  output logic                   rb_we,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_src,
  output logic [3:0]             state,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_EXEC_I    = 4'd11,
    S_I_WB      = 4'd12,
    S_ILLEGAL   = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  stateT                  r_state;
  stateT                  w_next;
  logic [COUNT_WIDTH-1:0] r_count;

  // State register. Reset takes priority, so an instruction interrupted
  // by reset never finishes its write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. The memory states hold until mem_ready. The opcode
  // stays valid past DECODE because the IR keeps it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:     w_next = S_FETCH;
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_EXEC_I;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_EXEC_I:    w_next = S_I_WB;
      S_I_WB:      w_next = S_FETCH;
      S_ILLEGAL:   w_next = S_ILLEGAL;
      default:     w_next = S_ILLEGAL;
    endcase
  end

  // Output decode. Controls depend mostly on the state. The only input
  // dependencies are the write enables that wait on mem_ready or zero.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rb_we      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        rb_we      = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        rb_we      = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB: begin
        rb_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Retired-instruction counter. It wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (instr_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. It runs a reference model
// that expands each instruction into the state sequence it should take.
// The sequence includes memory wait cycles. The model then checks the
// controls of every cycle against the opcode's rules.
module tb_multicycle_control;

  localparam int CW    = 4;
  localparam int CMASK = (1 << CW) - 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_we, ir_we, rb_we, i_or_d, mem_read, mem_write;
  logic          mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic          instr_done, illegal_op;
  logic [CW-1:0] instr_count;
  logic [14:0]   ctrlBus;

  int checks   = 0;
  int failures = 0;
  int modelCount = 0;

  multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .rb_we       (rb_we),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  assign ctrlBus = {pc_we, ir_we, rb_we, i_or_d, mem_read, mem_write,
                    mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src};

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Expected {instr_done, illegal_op, controls} for a state code, read off
  // the per-state output rules.
  function automatic logic [16:0] expOut(input int st, input bit mr, input bit z);
    bit pcWe, irWe, rbWe, iOrD, memRd, memWr, memToReg, regDst, srcA, done, ill;
    bit [1:0] srcB, aluOp, pcSrc;
    {pcWe, irWe, rbWe, iOrD, memRd, memWr, memToReg, regDst, srcA, done, ill} = '0;
    srcB = 2'd0; aluOp = 2'd0; pcSrc = 2'd0;
    case (st)
      1:  begin memRd = 1; srcB = 2'd1; pcWe = mr; irWe = mr; end
      2:  begin srcB = 2'd3; end
      3:  begin srcA = 1; srcB = 2'd2; end
      4:  begin iOrD = 1; memRd = 1; end
      5:  begin rbWe = 1; memToReg = 1; done = 1; end
      6:  begin iOrD = 1; memWr = 1; done = mr; end
      7:  begin srcA = 1; aluOp = 2'd2; end
      8:  begin rbWe = 1; regDst = 1; done = 1; end
      9:  begin srcA = 1; aluOp = 2'd1; pcSrc = 2'd1; pcWe = z; done = 1; end
      10: begin pcSrc = 2'd2; pcWe = 1; done = 1; end
      11: begin srcA = 1; srcB = 2'd2; end
      12: begin rbWe = 1; done = 1; end
      15: begin ill = 1; end
      default: begin end
    endcase
    return {done, ill, pcWe, irWe, rbWe, iOrD, memRd, memWr, memToReg, regDst,
            srcA, srcB, aluOp, pcSrc};
  endfunction

  function automatic bit isLegal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Runs one instruction. wf and wm are the wait cycles in fetch and in
  // the data access. zmode 0/1 forces zero, 2 randomizes it. limit stops
  // the run early so reset can hit mid-instruction (-1 runs it all).
  task automatic applyStimulus(input logic [5:0] opc, input int wf, input int wm,
                               input int zmode, input int limit);
    int stQ[$];
    bit mrQ[$];
    int n;
    logic [16:0] exp;
    for (int i = 0; i < wf; i++) begin stQ.push_back(1); mrQ.push_back(1'b0); end
    stQ.push_back(1); mrQ.push_back(1'b1);
    stQ.push_back(2); mrQ.push_back(1'($urandom_range(0, 1)));
    case (opc)
      OP_RTYPE: begin
        stQ.push_back(7); mrQ.push_back(1'($urandom_range(0, 1)));
        stQ.push_back(8); mrQ.push_back(1'($urandom_range(0, 1)));
      end
      OP_ADDI: begin
        stQ.push_back(11); mrQ.push_back(1'($urandom_range(0, 1)));
        stQ.push_back(12); mrQ.push_back(1'($urandom_range(0, 1)));
      end
      OP_LW: begin
        stQ.push_back(3); mrQ.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin stQ.push_back(4); mrQ.push_back(1'b0); end
        stQ.push_back(4); mrQ.push_back(1'b1);
        stQ.push_back(5); mrQ.push_back(1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        stQ.push_back(3); mrQ.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin stQ.push_back(6); mrQ.push_back(1'b0); end
        stQ.push_back(6); mrQ.push_back(1'b1);
      end
      OP_BEQ: begin stQ.push_back(9); mrQ.push_back(1'($urandom_range(0, 1))); end
      OP_J:   begin stQ.push_back(10); mrQ.push_back(1'($urandom_range(0, 1))); end
      default: begin
        for (int i = 0; i < 10; i++) begin
          stQ.push_back(15); mrQ.push_back(1'($urandom_range(0, 1)));
        end
      end
    endcase
    n = (limit < 0 || limit > stQ.size()) ? stQ.size() : limit;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      opcode    = opc;
      mem_ready = mrQ[k];
      zero      = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1;
      exp = expOut(stQ[k], mem_ready, zero);
      checkOutput("state", 32'(state), 32'(stQ[k]));
      checkOutput("ctrl", 32'(ctrlBus), 32'(exp[14:0]));
      checkOutput("instr_done", 32'(instr_done), 32'(exp[16]));
      checkOutput("illegal_op", 32'(illegal_op), 32'(exp[15]));
      checkOutput("instr_count", 32'(instr_count), 32'(modelCount));
      if (exp[16]) modelCount = (modelCount + 1) & CMASK;
    end
  endtask

  // Asserts reset for one edge and checks that everything clears, then
  // releases reset.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_ctrl"}, 32'(ctrlBus), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    checkOutput({tag, "_count"}, 32'(instr_count), 32'd0);
    modelCount = 0;
    rst = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    logic [5:0] legalOps [6];
    logic [5:0] badOp;
    legalOps[0] = OP_RTYPE; legalOps[1] = OP_LW;  legalOps[2] = OP_SW;
    legalOps[3] = OP_BEQ;   legalOps[4] = OP_J;   legalOps[5] = OP_ADDI;

    // Reset held for two cycles, then released with mem_ready high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_ctrl", 32'(ctrlBus), 32'd0);
      checkOutput("rst_done", 32'(instr_done), 32'd0);
      checkOutput("rst_illegal", 32'(illegal_op), 32'd0);
      checkOutput("rst_count", 32'(instr_count), 32'd0);
    end
    rst = 1'b0;
    mem_ready = 1'b1;

    // Directed cases: R-type, lw with three read waits, beq taken and not taken.
    applyStimulus(OP_RTYPE, 0, 0, 2, -1);
    applyStimulus(OP_LW, 0, 3, 2, -1);
    applyStimulus(OP_BEQ, 0, 0, 1, -1);
    applyStimulus(OP_BEQ, 0, 0, 0, -1);
    applyStimulus(OP_SW, 1, 2, 2, -1);
    applyStimulus(OP_ADDI, 0, 0, 2, -1);

    // Random instruction mix with random wait states.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(legalOps[$urandom_range(0, 5)], $urandom_range(0, 2),
                    $urandom_range(0, 3), 2, -1);
    end

    // Reset during a stalled lw read. No writeback may follow.
    applyStimulus(OP_LW, 0, 3, 2, 4);
    resetPulse("midrst");

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) applyStimulus(OP_J, 0, 0, 2, -1);
    @(posedge clk);
    #1;
    checkOutput("wrap_count", 32'(instr_count), 32'd0);
    checkOutput("wrap_state", 32'(state), 32'd1);

    // Illegal opcode traps, then only reset clears it.
    applyStimulus(6'b111111, 0, 0, 2, -1);
    resetPulse("ill_rst");
    applyStimulus(OP_RTYPE, 0, 0, 2, -1);
    badOp = 6'($urandom_range(0, 63));
    while (isLegal(badOp)) badOp = 6'($urandom_range(0, 63));
    applyStimulus(badOp, 2, 0, 2, -1);
    resetPulse("ill_rst2");
    applyStimulus(OP_J, 0, 0, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
